// File: rtl/mppt_pkg.sv
// Shared definitions for the MPPT tracker cores: state codes, flag bit
// positions, default bus widths and the dwell-counter width helper.
package mppt_pkg;

  localparam int STATE_W_DEF = 3;
  localparam int FLAG_W_DEF  = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MEAS    = 3'd1;
  localparam logic [2:0] ST_PERT_UP = 3'd2;
  localparam logic [2:0] ST_PERT_DN = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  localparam int FLG_STEP_DONE = 0;
  localparam int FLG_FAULT     = 1;

  // Counter must hold the value SETTLE_CYC; a zero dwell still needs one bit.
  function automatic int cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/mppt_core_regs_ch.sv
// One tracker channel: state register with minimum-dwell gating, flag
// register (plain or sticky), state-change pulse and settled indication.
module mppt_core_regs_ch
  import mppt_pkg::*;
#(
  parameter int STATE_W    = STATE_W_DEF,
  parameter int FLAG_W     = FLAG_W_DEF,
  parameter int SETTLE_CYC = 8,
  parameter int STICKY     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [STATE_W-1:0] nstate,
  input  logic               force_req,
  input  logic [FLAG_W-1:0]  flag_i,
  input  logic [FLAG_W-1:0]  flag_clr,
  output logic [STATE_W-1:0] state,
  output logic [FLAG_W-1:0]  flag_o,
  output logic               state_chg,
  output logic               settled
);

  localparam int              CNT_W     = cnt_width(SETTLE_CYC);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(SETTLE_CYC);

  logic [STATE_W-1:0] state_reg;
  logic [FLAG_W-1:0]  flag_reg;
  logic [FLAG_W-1:0]  flag_next;
  logic [CNT_W-1:0]   dwell_reg;
  logic [CNT_W-1:0]   dwell_next;
  logic               chg_reg;
  logic               settled_w;
  logic               accept;

  always_comb begin
    settled_w  = (dwell_reg == DWELL_MAX);
    accept     = (nstate != state_reg) && (settled_w || force_req);
    // Saturate so a long-idle channel stays settled instead of wrapping.
    dwell_next = settled_w ? dwell_reg : dwell_reg + CNT_W'(1);
    // Set is ORed in after the clear, so a simultaneous set survives.
    flag_next  = (STICKY != 0) ? ((flag_reg & ~flag_clr) | flag_i) : flag_i;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= '0;
      flag_reg  <= '0;
      dwell_reg <= '0;
      chg_reg   <= 1'b0;
    end else if (en) begin
      flag_reg <= flag_next;
      if (accept) begin
        state_reg <= nstate;
        dwell_reg <= '0;
        chg_reg   <= 1'b1;
      end else begin
        dwell_reg <= dwell_next;
        chg_reg   <= 1'b0;
      end
    end else begin
      chg_reg <= 1'b0;
    end
  end

  assign state     = state_reg;
  assign flag_o    = flag_reg;
  assign state_chg = chg_reg;
  assign settled   = settled_w;

endmodule

// File: rtl/mppt_core_regs_multi.sv
// Multi-channel MPPT state/flag register bank: N_CH independent channels,
// each a mppt_core_regs_ch; this level only slices the packed buses.
module mppt_core_regs_multi
  import mppt_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int STATE_W    = STATE_W_DEF,
  parameter int FLAG_W     = FLAG_W_DEF,
  parameter int SETTLE_CYC = 8,
  parameter int STICKY     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_CH*STATE_W-1:0]   nstate,
  input  logic [N_CH-1:0]           force_req,
  input  logic [N_CH*FLAG_W-1:0]    flag_i,
  input  logic [N_CH*FLAG_W-1:0]    flag_clr,
  output logic [N_CH*STATE_W-1:0]   state,
  output logic [N_CH*FLAG_W-1:0]    flag_o,
  output logic [N_CH-1:0]           state_chg,
  output logic [N_CH-1:0]           settled
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    mppt_core_regs_ch #(
      .STATE_W   (STATE_W),
      .FLAG_W    (FLAG_W),
      .SETTLE_CYC(SETTLE_CYC),
      .STICKY    (STICKY)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .nstate   (nstate[gi*STATE_W +: STATE_W]),
      .force_req(force_req[gi]),
      .flag_i   (flag_i[gi*FLAG_W +: FLAG_W]),
      .flag_clr (flag_clr[gi*FLAG_W +: FLAG_W]),
      .state    (state[gi*STATE_W +: STATE_W]),
      .flag_o   (flag_o[gi*FLAG_W +: FLAG_W]),
      .state_chg(state_chg[gi]),
      .settled  (settled[gi])
    );
  end

endmodule

// File: tb/tb_mppt_core_regs_multi.sv
// Directed bench for mppt_core_regs_multi: a 2-channel dwell/sticky instance
// and a 1-channel pass-through instance driven with a random sequence.
module tb_mppt_core_regs_multi;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic rst;

  logic       a_en;
  logic [5:0] a_nstate;
  logic [1:0] a_force;
  logic [3:0] a_flag_i, a_flag_clr;
  logic [5:0] a_state;
  logic [3:0] a_flag_o;
  logic [1:0] a_chg, a_settled;

  logic       b_en;
  logic [2:0] b_nstate;
  logic [0:0] b_force;
  logic [1:0] b_flag_i, b_flag_clr;
  logic [2:0] b_state;
  logic [1:0] b_flag_o;
  logic [0:0] b_chg, b_settled;

  mppt_core_regs_multi #(
    .N_CH(2), .STATE_W(3), .FLAG_W(2), .SETTLE_CYC(8), .STICKY(1)
  ) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .nstate(a_nstate), .force_req(a_force),
    .flag_i(a_flag_i), .flag_clr(a_flag_clr), .state(a_state), .flag_o(a_flag_o),
    .state_chg(a_chg), .settled(a_settled)
  );

  mppt_core_regs_multi #(
    .N_CH(1), .STATE_W(3), .FLAG_W(2), .SETTLE_CYC(0), .STICKY(0)
  ) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .nstate(b_nstate), .force_req(b_force),
    .flag_i(b_flag_i), .flag_clr(b_flag_clr), .state(b_state), .flag_o(b_flag_o),
    .state_chg(b_chg), .settled(b_settled)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [2:0] exp_state, drv_state;
  logic [1:0] drv_flag;

  initial begin
    rst = 1'b0;
    a_en = 1'b0; a_nstate = '0; a_force = '0; a_flag_i = '0; a_flag_clr = '0;
    b_en = 1'b0; b_nstate = '0; b_force = '0; b_flag_i = '0; b_flag_clr = '0;
    #2;
    chk("rst_a_state",   32'(a_state),   32'h0);
    chk("rst_a_flag",    32'(a_flag_o),  32'h0);
    chk("rst_a_chg",     32'(a_chg),     32'h0);
    chk("rst_a_settled", 32'(a_settled), 32'h0);
    chk("rst_b_settled", 32'(b_settled), 32'h1);

    // Dwell: request state 2 on both channels straight out of reset
    rst = 1'b1;
    a_en = 1'b1;
    a_nstate = {3'd2, 3'd2};
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("dwell_state_e%0d", i), 32'(a_state), 32'h0);
      chk($sformatf("dwell_settled_e%0d", i), 32'(a_settled), 32'h0);
    end
    tick();
    chk("dwell_state_e8",   32'(a_state),   32'h0);
    chk("dwell_settled_e8", 32'(a_settled), 32'h3);
    tick();
    chk("dwell_state_e9",   32'(a_state),   32'h12);
    chk("dwell_chg_e9",     32'(a_chg),     32'h3);
    chk("dwell_settled_e9", 32'(a_settled), 32'h0);
    tick();
    chk("dwell_chg_e10", 32'(a_chg), 32'h0);
    tick();
    tick();
    chk("pre_force_settled", 32'(a_settled), 32'h0);

    // Force ch0 at dwell 3; ch1 asks too but is not settled
    a_nstate = {3'd5, 3'd5};
    a_force  = 2'b01;
    tick();
    chk("force_state", 32'(a_state), 32'h15);
    chk("force_chg",   32'(a_chg),   32'h1);
    a_nstate = {3'd2, 3'd5};
    tick();
    chk("force_same_chg",   32'(a_chg),   32'h0);
    chk("force_same_state", 32'(a_state), 32'h15);

    // Bring ch0 to dwell 4 (ch1 settles meanwhile), then hold with en=0
    a_force = 2'b00;
    tick(); tick(); tick();
    chk("pre_hold_settled", 32'(a_settled), 32'h2);
    a_en = 1'b0;
    a_nstate = {3'd2, 3'd3};
    a_flag_i = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("hold_state_%0d", i), 32'(a_state),  32'h15);
      chk($sformatf("hold_chg_%0d", i),   32'(a_chg),    32'h0);
      chk($sformatf("hold_flag_%0d", i),  32'(a_flag_o), 32'h0);
    end
    a_en = 1'b1;
    a_nstate = {3'd2, 3'd5};
    a_flag_i = 4'h0;
    tick(); tick(); tick();
    chk("resume_dwell7", 32'(a_settled), 32'h2);
    tick();
    chk("resume_dwell8", 32'(a_settled), 32'h3);

    // Sticky flags
    a_flag_i = 4'b10_01;
    tick();
    chk("sticky_set", 32'(a_flag_o), 32'h9);
    a_flag_i = 4'b00_00;
    tick();
    chk("sticky_keep", 32'(a_flag_o), 32'h9);
    a_flag_i = 4'b00_01; a_flag_clr = 4'b00_01;
    tick();
    chk("sticky_set_wins", 32'(a_flag_o), 32'h9);
    a_flag_i = 4'b00_00; a_flag_clr = 4'b11_01;
    tick();
    chk("sticky_clear", 32'(a_flag_o), 32'h0);
    a_flag_clr = 4'b00_00;

    // Reset mid-run with states 5/3 and flags set
    a_nstate = {3'd3, 3'd5};
    a_flag_i = 4'hF;
    tick();
    chk("pre_rst_state", 32'(a_state),  32'h1D);
    chk("pre_rst_chg",   32'(a_chg),    32'h2);
    chk("pre_rst_flag",  32'(a_flag_o), 32'hF);
    rst = 1'b0;
    #1;
    chk("mid_rst_state",   32'(a_state),   32'h0);
    chk("mid_rst_flag",    32'(a_flag_o),  32'h0);
    chk("mid_rst_chg",     32'(a_chg),     32'h0);
    chk("mid_rst_settled", 32'(a_settled), 32'h0);
    rst = 1'b1;
    a_flag_i = 4'h0;
    tick();
    chk("post_rst_state", 32'(a_state), 32'h0);
    chk("post_rst_chg",   32'(a_chg),   32'h0);

    // Pass-through instance: one falling edge of latency, random sequence
    b_en = 1'b1;
    exp_state = 3'd0;
    for (int i = 0; i < 1000; i++) begin
      drv_state = 3'($urandom_range(0, 7));
      drv_flag  = 2'($urandom_range(0, 3));
      b_nstate   = drv_state;
      b_flag_i   = drv_flag;
      b_force    = 1'($urandom_range(0, 1));
      b_flag_clr = 2'($urandom_range(0, 3));
      tick();
      chk($sformatf("legacy_state_%0d", i), 32'(b_state),  32'(drv_state));
      chk($sformatf("legacy_flag_%0d", i),  32'(b_flag_o), 32'(drv_flag));
      chk($sformatf("legacy_chg_%0d", i),   32'(b_chg),    32'(drv_state != exp_state));
      exp_state = drv_state;
    end
    chk("legacy_settled", 32'(b_settled), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
